// File: rtl/excesso3_pkg.sv
// Shared constants and state encoding for the serial excess-3 deserializer.
package excesso3_pkg;
   localparam logic [3:0] E3_OFFSET   = 4'd3;
   localparam logic [3:0] E3_MIN      = 4'd3;
   localparam logic [3:0] E3_MAX      = 4'd12;
   localparam logic [3:0] BCD_INVALID = 4'hF;

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } state_t;
endpackage

// File: rtl/excesso3_para_bcd.sv
// Combinational excess-3 to BCD digit decoder; out-of-range codes map to BCD_INVALID.
module excesso3_para_bcd
   import excesso3_pkg::*;
(
   input  logic [3:0] code,
   output logic [3:0] digit,
   output logic       invalid
);

   always_comb begin
      invalid = (code < E3_MIN) || (code > E3_MAX);
      digit   = invalid ? BCD_INVALID : (code - E3_OFFSET);
   end

endmodule

// File: rtl/excesso3_deserializador.sv
// Serial excess-3 receiver: decodes LSB-first 4-bit codes into BCD and packs NDIG
// digits per word, delivered through a one-entry valid/ready output register.
module excesso3_deserializador
   import excesso3_pkg::*;
#(
   parameter int NDIG = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              Bin,
   input  logic              Bin_valid,
   input  logic              sync,
   output logic [4*NDIG-1:0] word_out,
   output logic              word_err,
   output logic              word_valid,
   input  logic              word_ready,
   output logic              overrun,
   output logic              sync_err
);

   localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int WW = 4 * NDIG;
   localparam logic [DW-1:0] LAST_DIG = DW'(NDIG - 1);

   state_t          state_q, state_d;
   logic [1:0]      bit_cnt_q, bit_cnt_d;
   logic [DW-1:0]   dig_cnt_q, dig_cnt_d;
   // Only the three most recent bits are kept; the fourth arrives live on Bin.
   logic [3:1]      shift_reg_q, shift_reg_d;
   logic [WW-1:0]   part_q, part_d;
   logic            part_err_q, part_err_d;
   logic [WW-1:0]   word_out_q, word_out_d;
   logic            word_err_q, word_err_d;
   logic            word_valid_q, word_valid_d;
   logic            overrun_q, overrun_d;
   logic            sync_err_q, sync_err_d;

   logic [3:0]      code;
   logic [3:0]      digit;
   logic            invalid;
   logic [WW-1:0]   part_fill;
   logic            complete;

   assign code = {Bin, shift_reg_q[3:1]};

   excesso3_para_bcd u_para_bcd (
      .code    (code),
      .digit   (digit),
      .invalid (invalid)
   );

   // Partial word with the digit being completed dropped into its nibble.
   generate
      for (genvar gi = 0; gi < NDIG; gi++) begin : g_fill
         assign part_fill[gi*4 +: 4] = (dig_cnt_q == DW'(gi)) ? digit : part_q[gi*4 +: 4];
      end
   endgenerate

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      dig_cnt_d    = dig_cnt_q;
      shift_reg_d  = shift_reg_q;
      part_d       = part_q;
      part_err_d   = part_err_q;
      word_out_d   = word_out_q;
      word_err_d   = word_err_q;
      word_valid_d = word_valid_q;
      overrun_d    = 1'b0;
      sync_err_d   = 1'b0;
      complete     = 1'b0;

      if (word_valid_q && word_ready) begin
         word_valid_d = 1'b0;
      end

      if (Bin_valid) begin
         case (state_q)
            IDLE: begin
               if (sync) begin
                  state_d     = RECV;
                  shift_reg_d = {Bin, shift_reg_q[3:2]};
                  bit_cnt_d   = 2'd1;
                  dig_cnt_d   = '0;
                  part_d      = '0;
                  part_err_d  = 1'b0;
               end
            end
            RECV: begin
               shift_reg_d = {Bin, shift_reg_q[3:2]};
               if (sync && ((bit_cnt_q != 2'd0) || (dig_cnt_q != '0))) begin
                  sync_err_d = 1'b1;
                  part_d     = '0;
                  part_err_d = 1'b0;
                  bit_cnt_d  = 2'd1;
                  dig_cnt_d  = '0;
               end else if (bit_cnt_q == 2'd3) begin
                  bit_cnt_d = 2'd0;
                  if (dig_cnt_q == LAST_DIG) begin
                     dig_cnt_d  = '0;
                     part_d     = '0;
                     part_err_d = 1'b0;
                     complete   = 1'b1;
                  end else begin
                     dig_cnt_d  = dig_cnt_q + 1'b1;
                     part_d     = part_fill;
                     part_err_d = part_err_q | invalid;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 2'd1;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // A held word that is being popped on this edge may be replaced in place.
      if (complete) begin
         if (!word_valid_q || word_ready) begin
            word_out_d   = part_fill;
            word_err_d   = part_err_q | invalid;
            word_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         dig_cnt_q    <= '0;
         shift_reg_q  <= '0;
         part_q       <= '0;
         part_err_q   <= 1'b0;
         word_out_q   <= '0;
         word_err_q   <= 1'b0;
         word_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
         sync_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         dig_cnt_q    <= dig_cnt_d;
         shift_reg_q  <= shift_reg_d;
         part_q       <= part_d;
         part_err_q   <= part_err_d;
         word_out_q   <= word_out_d;
         word_err_q   <= word_err_d;
         word_valid_q <= word_valid_d;
         overrun_q    <= overrun_d;
         sync_err_q   <= sync_err_d;
      end
   end

   assign word_out   = word_out_q;
   assign word_err   = word_err_q;
   assign word_valid = word_valid_q;
   assign overrun    = overrun_q;
   assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_excesso3_deserializador.sv
// Directed bench for excesso3_deserializador with NDIG=2; inputs change on the
// falling edge, outputs are checked on the falling edge after each sampled bit.
module tb_excesso3_deserializador;

   logic       clk;
   logic       reset_n;
   logic       Bin;
   logic       Bin_valid;
   logic       sync;
   logic [7:0] word_out;
   logic       word_err;
   logic       word_valid;
   logic       word_ready;
   logic       overrun;
   logic       sync_err;

   int checks = 0;
   int errors = 0;
   logic any_activity;

   excesso3_deserializador #(.NDIG(2)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .Bin        (Bin),
      .Bin_valid  (Bin_valid),
      .sync       (sync),
      .word_out   (word_out),
      .word_err   (word_err),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .overrun    (overrun),
      .sync_err   (sync_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called on a falling edge; returns on the next falling edge after the bit was sampled.
   task automatic bit_(input logic b, input logic s);
      Bin       = b;
      sync      = s;
      Bin_valid = 1'b1;
      @(negedge clk);
      Bin_valid = 1'b0;
      sync      = 1'b0;
      Bin       = 1'b0;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic gap(input int max_gap);
      int n;
      n = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (n) @(negedge clk);
   endtask

   // Everything except the final bit of a two-digit word.
   task automatic send_pre(input logic [3:0] c0, input logic [3:0] c1, input logic s, input int max_gap);
      for (int i = 0; i < 4; i++) begin
         gap(max_gap);
         bit_(c0[i], s && (i == 0));
      end
      for (int i = 0; i < 3; i++) begin
         gap(max_gap);
         bit_(c1[i], 1'b0);
      end
   endtask

   task automatic send_word(input logic [3:0] c0, input logic [3:0] c1, input logic s, input int max_gap);
      send_pre(c0, c1, s, max_gap);
      gap(max_gap);
      bit_(c1[3], 1'b0);
      $display("word codes %b %b: out=%h err=%b valid=%b", c1, c0, word_out, word_err, word_valid);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_out"},   {24'd0, word_out}, 32'h0);
      chk({tag, "_err"},   {31'd0, word_err}, 32'h0);
      chk({tag, "_valid"}, {31'd0, word_valid}, 32'h0);
      chk({tag, "_ovr"},   {31'd0, overrun}, 32'h0);
      chk({tag, "_serr"},  {31'd0, sync_err}, 32'h0);
   endtask

   initial begin
      reset_n    = 1'b0;
      Bin        = 1'b0;
      Bin_valid  = 1'b0;
      sync       = 1'b0;
      word_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      reset_n = 1'b1;
      tick();

      // IDLE: bits without sync are ignored
      any_activity = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bit_(i[0], 1'b0);
         any_activity = any_activity | word_valid | overrun | sync_err;
      end
      tick();
      any_activity = any_activity | word_valid | overrun | sync_err;
      chk("idle_quiet", {31'd0, any_activity}, 32'h0);

      // Decode 8 -> 5, 12 -> 9, valid exactly one cycle after the last bit
      send_pre(4'b1000, 4'b1100, 1'b1, 0);
      chk("dec_valid_before", {31'd0, word_valid}, 32'h0);
      bit_(1'b1, 1'b0);
      chk("dec_valid", {31'd0, word_valid}, 32'h1);
      chk("dec_out",   {24'd0, word_out}, 32'h95);
      chk("dec_err",   {31'd0, word_err}, 32'h0);
      tick();
      chk("dec_pop", {31'd0, word_valid}, 32'h0);

      // Invalid codes, back-to-back words without sync
      send_word(4'b1111, 4'b0110, 1'b1, 0);
      chk("inv_out", {24'd0, word_out}, 32'h3F);
      chk("inv_err", {31'd0, word_err}, 32'h1);
      send_word(4'b0010, 4'b1000, 1'b0, 0);
      chk("inv2_out", {24'd0, word_out}, 32'h5F);
      chk("inv2_err", {31'd0, word_err}, 32'h1);
      tick();
      send_word(4'b1000, 4'b1100, 1'b0, 0);
      chk("clean_after_err_out", {24'd0, word_out}, 32'h95);
      chk("clean_after_err_err", {31'd0, word_err}, 32'h0);
      tick();

      // Backpressure: second word dropped with overrun
      word_ready = 1'b0;
      send_word(4'b1000, 4'b1100, 1'b1, 0);
      chk("bp_valid", {31'd0, word_valid}, 32'h1);
      chk("bp_ovr0",  {31'd0, overrun}, 32'h0);
      send_word(4'b0110, 4'b0110, 1'b0, 0);
      chk("bp_ovr",  {31'd0, overrun}, 32'h1);
      chk("bp_hold", {24'd0, word_out}, 32'h95);
      tick();
      chk("bp_ovr_pulse", {31'd0, overrun}, 32'h0);
      chk("bp_still_valid", {31'd0, word_valid}, 32'h1);
      chk("bp_still_out", {24'd0, word_out}, 32'h95);
      word_ready = 1'b1;
      tick();
      chk("bp_accept", {31'd0, word_valid}, 32'h0);
      tick();
      chk("bp_accept_ovr", {31'd0, overrun}, 32'h0);

      // Pop and load on the same edge
      word_ready = 1'b0;
      send_word(4'b1000, 4'b1100, 1'b0, 0);
      chk("pl_first", {24'd0, word_out}, 32'h95);
      send_pre(4'b0110, 4'b0110, 1'b0, 0);
      word_ready = 1'b1;
      bit_(1'b0, 1'b0);
      chk("pl_valid", {31'd0, word_valid}, 32'h1);
      chk("pl_out",   {24'd0, word_out}, 32'h33);
      chk("pl_ovr",   {31'd0, overrun}, 32'h0);
      tick();
      chk("pl_pop", {31'd0, word_valid}, 32'h0);

      // sync mid-word: 3 bits of digit 0 then resync
      bit_(1'b0, 1'b0);
      bit_(1'b0, 1'b0);
      bit_(1'b0, 1'b0);
      chk("se_quiet", {31'd0, sync_err}, 32'h0);
      bit_(1'b0, 1'b1);
      chk("se_pulse", {31'd0, sync_err}, 32'h1);
      bit_(1'b0, 1'b0);
      chk("se_pulse_end", {31'd0, sync_err}, 32'h0);
      bit_(1'b1, 1'b0);
      bit_(1'b1, 1'b0);
      bit_(1'b0, 1'b0);
      bit_(1'b0, 1'b0);
      bit_(1'b1, 1'b0);
      bit_(1'b1, 1'b0);
      chk("se_valid", {31'd0, word_valid}, 32'h1);
      chk("se_out",   {24'd0, word_out}, 32'h99);
      chk("se_err",   {31'd0, word_err}, 32'h0);
      tick();

      // Resync after a complete invalid digit: its err bit is dropped
      for (int i = 0; i < 4; i++) bit_(1'b1, 1'b0);
      bit_(1'b0, 1'b0);
      send_word(4'b1100, 4'b1100, 1'b1, 0);
      chk("se2_out", {24'd0, word_out}, 32'h99);
      chk("se2_err", {31'd0, word_err}, 32'h0);
      tick();

      // Random Bin_valid gaps inside a word
      send_word(4'b1000, 4'b0110, 1'b1, 3);
      chk("gap_valid", {31'd0, word_valid}, 32'h1);
      chk("gap_out",   {24'd0, word_out}, 32'h35);
      chk("gap_err",   {31'd0, word_err}, 32'h0);
      tick();

      // Async reset mid-word
      for (int i = 0; i < 5; i++) bit_(1'b1, 1'b0);
      #2 reset_n = 1'b0;
      #1 chk_all_zero("rst_mid");
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // Async reset while a word is held
      word_ready = 1'b0;
      send_word(4'b1111, 4'b1000, 1'b1, 0);
      chk("rstv_pre_valid", {31'd0, word_valid}, 32'h1);
      chk("rstv_pre_err",   {31'd0, word_err}, 32'h1);
      #2 reset_n = 1'b0;
      #1 chk_all_zero("rst_valid");
      @(negedge clk);
      reset_n    = 1'b1;
      word_ready = 1'b1;
      tick();

      // Fresh word after reset release
      send_word(4'b1100, 4'b0110, 1'b1, 0);
      chk("post_valid", {31'd0, word_valid}, 32'h1);
      chk("post_out",   {24'd0, word_out}, 32'h39);
      chk("post_err",   {31'd0, word_err}, 32'h0);
      tick();
      chk("post_pop", {31'd0, word_valid}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
